// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if
// Bundles the FIFO read-side handshake and the serial-line outputs of
// fifo_uart_tx so the transmitter and its environment connect through one port.
//   enable_i      : permits new frames to start
//   fifo_empty_i  : FIFO empty flag
//   fifo_data_i   : FIFO head word, valid while fifo_empty_i is low
//   fifo_pop_o    : one-cycle pop strobe per frame
//   tx_o          : serial line, idle high
//   busy_o        : high for every cycle of a frame on tx_o
//   sent_o        : pulse in the final stop-bit cycle
// The slave modport is the transmitter; the master modport is the environment.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable_i;
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_pop_o;
    logic                  tx_o;
    logic                  busy_o;
    logic                  sent_o;

    modport slave (
        input  enable_i, fifo_empty_i, fifo_data_i,
        output fifo_pop_o, tx_o, busy_o, sent_o
    );

    modport master (
        output enable_i, fifo_empty_i, fifo_data_i,
        input  fifo_pop_o, tx_o, busy_o, sent_o
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops words from a synchronous FIFO and serializes each as a UART frame:
// start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
// Frames go out back-to-back with no idle gap while the FIFO stays non-empty.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : fifo_uart_tx_if.slave (enable, FIFO read side, tx line, status)
// Parameters: DATA_WIDTH (5..9), CLKS_PER_BIT (>=2), PARITY_EN, PARITY_ODD.
module fifo_uart_tx #(
    parameter int   DATA_WIDTH   = 8,
    parameter int   CLKS_PER_BIT = 16,
    parameter logic PARITY_EN    = 1'b0,
    parameter logic PARITY_ODD   = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fifo_uart_tx_if.slave bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity of a data word (XOR of all bits).
    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_sent;

    state_t                w_next_state;
    logic [BAUD_W-1:0]     w_baud_next;
    logic [IDX_W-1:0]      w_bit_idx_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_parity_next;
    logic                  w_launch;
    logic                  w_baud_end;
    logic                  w_pop;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  w_sent_next;

    // rst_ni is part of the launch term so no pop can leak out during reset.
    assign w_launch   = bus.enable_i & ~bus.fifo_empty_i & rst_ni;
    assign w_baud_end = (r_baud == BAUD_LAST);

    // State register and all datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_sent    <= w_sent_next;
        end
    end

    // Next-state, bit index, shift register and baud counter.
    always_comb begin
        w_next_state   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_next_state  = ST_START;
                    w_shift_next  = bus.fifo_data_i;
                    w_parity_next = parity_f(bus.fifo_data_i) ^ PARITY_ODD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_next_state   = ST_DATA;
                    w_bit_idx_next = '0;
                end else begin
                    w_next_state = ST_START;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    if (r_bit_idx == IDX_LAST) begin
                        w_bit_idx_next = '0;
                        w_next_state   = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_baud_end) begin
                    w_next_state = ST_STOP;
                end else begin
                    w_next_state = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Reloading here, in the last stop cycle, is what keeps
                // back-to-back frames free of an idle bit.
                if (w_baud_end) begin
                    if (w_launch) begin
                        w_next_state  = ST_START;
                        w_shift_next  = bus.fifo_data_i;
                        w_parity_next = parity_f(bus.fifo_data_i) ^ PARITY_ODD;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_STOP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if ((r_state == ST_IDLE) || w_baud_end) begin
            w_baud_next = '0;
        end else begin
            w_baud_next = r_baud + BAUD_W'(1);
        end
    end

    // Outputs: combinational pop, and next values of the registered line/status.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = w_launch;
            ST_STOP: w_pop = w_launch & w_baud_end;
            default: w_pop = 1'b0;
        endcase

        // The line is registered, so it is driven from the state being entered.
        w_tx_next = 1'b1;
        case (w_next_state)
            ST_IDLE:   w_tx_next = 1'b1;
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = w_parity_next;
            ST_STOP:   w_tx_next = 1'b1;
            default:   w_tx_next = 1'b1;
        endcase

        w_busy_next = (w_next_state != ST_IDLE);
        w_sent_next = (w_next_state == ST_STOP) && (w_baud_next == BAUD_LAST);
    end

    assign bus.fifo_pop_o = w_pop;
    assign bus.tx_o       = r_tx;
    assign bus.busy_o     = r_busy;
    assign bus.sent_o     = r_sent;

endmodule
